// File: rtl/ctrl_pkg.sv
// Shared controller/datapath definitions: state encoding, opcodes, ALU selects, IR field bundle.
package ctrl_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALU_S_W  = 3;
  localparam int unsigned IR_W     = 16;
  localparam int unsigned FIELD_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOADA  = 4'd4,
    ST_LOADB  = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_e;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } op_e;

  localparam logic [ALU_S_W-1:0] ALU_PASS_A = 3'b000;
  localparam logic [ALU_S_W-1:0] ALU_ADD    = 3'b001;
  localparam logic [ALU_S_W-1:0] ALU_SUB    = 3'b010;

  // IR[11:8], IR[7:4], IR[3:0] with the opcode already folded to a legal op.
  typedef struct packed {
    op_e                op;
    logic [FIELD_W-1:0] f_hi;
    logic [FIELD_W-1:0] f_mid;
    logic [FIELD_W-1:0] f_lo;
  } ir_fields_t;

endpackage

// File: rtl/instr_field_decode.sv
// Combinational split of the instruction word into opcode and register/address nibbles.
module instr_field_decode
  import ctrl_pkg::*;
(
  input  logic [IR_W-1:0] i_ir,
  output ir_fields_t      o_fields
);

  always_comb begin
    o_fields.f_hi  = i_ir[11:8];
    o_fields.f_mid = i_ir[7:4];
    o_fields.f_lo  = i_ir[3:0];
    // Unassigned opcodes behave as NOOP.
    case (i_ir[15:12])
      4'h1:    o_fields.op = OP_STORE;
      4'h2:    o_fields.op = OP_LOAD;
      4'h3:    o_fields.op = OP_ADD;
      4'h4:    o_fields.op = OP_SUB;
      4'h5:    o_fields.op = OP_HALT;
      default: o_fields.op = OP_NOOP;
    endcase
  end

endmodule

// File: rtl/controller_fsm.sv
// Multi-cycle CPU controller: fetch/decode/execute sequencing with registered control outputs.
// Define CTRL_DEBUG_STATE_EN to expose State/NextState debug ports.
module controller_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned D_ADDR_W  = 8,
  parameter int unsigned RF_ADDR_W = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [IR_W-1:0]      IR,
  output logic                 PC_clr,
  output logic                 PC_up,
  output logic                 IR_ld,
  output logic [D_ADDR_W-1:0]  D_Addr,
  output logic                 D_Wr,
  output logic                 RF_s,
  output logic                 RF_W_en,
  output logic [RF_ADDR_W-1:0] RF_W_Addr,
  output logic [RF_ADDR_W-1:0] RF_Ra_Addr,
  output logic [RF_ADDR_W-1:0] RF_Rb_Addr,
  output logic [ALU_S_W-1:0]   ALU_s0
`ifdef CTRL_DEBUG_STATE_EN
  ,
  output logic [STATE_W-1:0]   State,
  output logic [STATE_W-1:0]   NextState
`endif
);

  state_e                 r_state;
  state_e                 w_next_state;
  ir_fields_t             w_f;
  logic [7:0]             w_load_addr;
  logic [7:0]             w_store_addr;

  logic                   w_pc_clr;
  logic                   w_pc_up;
  logic                   w_ir_ld;
  logic [D_ADDR_W-1:0]    w_d_addr;
  logic                   w_d_wr;
  logic                   w_rf_s;
  logic                   w_rf_w_en;
  logic [RF_ADDR_W-1:0]   w_rf_w_addr;
  logic [RF_ADDR_W-1:0]   w_rf_ra_addr;
  logic [RF_ADDR_W-1:0]   w_rf_rb_addr;
  logic [ALU_S_W-1:0]     w_alu_s0;

  instr_field_decode u_decode (
    .i_ir     (IR),
    .o_fields (w_f)
  );

  assign w_load_addr  = {w_f.f_hi, w_f.f_mid};
  assign w_store_addr = {w_f.f_mid, w_f.f_lo};

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_INIT:   w_next_state = ST_FETCH;
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (w_f.op)
          OP_STORE: w_next_state = ST_STORE;
          OP_LOAD:  w_next_state = ST_LOADA;
          OP_ADD:   w_next_state = ST_ADD;
          OP_SUB:   w_next_state = ST_SUB;
          OP_HALT:  w_next_state = ST_HALT;
          default:  w_next_state = ST_NOOP;
        endcase
      end
      ST_LOADA:  w_next_state = ST_LOADB;
      ST_NOOP, ST_LOADB, ST_STORE, ST_ADD, ST_SUB: w_next_state = ST_FETCH;
      ST_HALT:   w_next_state = ST_HALT;
      default:   w_next_state = ST_INIT;
    endcase
  end

  // Control values for the state being entered; registered below so they line up with it.
  always_comb begin
    w_pc_clr     = 1'b0;
    w_pc_up      = 1'b0;
    w_ir_ld      = 1'b0;
    w_d_addr     = '0;
    w_d_wr       = 1'b0;
    w_rf_s       = 1'b0;
    w_rf_w_en    = 1'b0;
    w_rf_w_addr  = '0;
    w_rf_ra_addr = '0;
    w_rf_rb_addr = '0;
    w_alu_s0     = ALU_PASS_A;
    case (w_next_state)
      ST_INIT:  w_pc_clr = 1'b1;
      ST_FETCH: begin
        w_ir_ld = 1'b1;
        w_pc_up = 1'b1;
      end
      ST_LOADA: w_d_addr = D_ADDR_W'(w_load_addr);
      ST_LOADB: begin
        w_d_addr    = D_ADDR_W'(w_load_addr);
        w_rf_w_addr = RF_ADDR_W'(w_f.f_lo);
        w_rf_s      = 1'b1;
        w_rf_w_en   = 1'b1;
      end
      ST_STORE: begin
        w_d_addr     = D_ADDR_W'(w_store_addr);
        w_rf_ra_addr = RF_ADDR_W'(w_f.f_hi);
        w_alu_s0     = ALU_PASS_A;
        w_d_wr       = 1'b1;
      end
      ST_ADD, ST_SUB: begin
        w_rf_ra_addr = RF_ADDR_W'(w_f.f_hi);
        w_rf_rb_addr = RF_ADDR_W'(w_f.f_mid);
        w_rf_w_addr  = RF_ADDR_W'(w_f.f_lo);
        w_rf_w_en    = 1'b1;
        w_alu_s0     = (w_next_state == ST_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_INIT;
      PC_clr     <= 1'b1;
      PC_up      <= 1'b0;
      IR_ld      <= 1'b0;
      D_Addr     <= '0;
      D_Wr       <= 1'b0;
      RF_s       <= 1'b0;
      RF_W_en    <= 1'b0;
      RF_W_Addr  <= '0;
      RF_Ra_Addr <= '0;
      RF_Rb_Addr <= '0;
      ALU_s0     <= ALU_PASS_A;
    end else begin
      r_state    <= w_next_state;
      PC_clr     <= w_pc_clr;
      PC_up      <= w_pc_up;
      IR_ld      <= w_ir_ld;
      D_Addr     <= w_d_addr;
      D_Wr       <= w_d_wr;
      RF_s       <= w_rf_s;
      RF_W_en    <= w_rf_w_en;
      RF_W_Addr  <= w_rf_w_addr;
      RF_Ra_Addr <= w_rf_ra_addr;
      RF_Rb_Addr <= w_rf_rb_addr;
      ALU_s0     <= w_alu_s0;
    end
  end

`ifdef CTRL_DEBUG_STATE_EN
  assign State     = r_state;
  assign NextState = w_next_state;
`endif

endmodule

// File: doc/controller_fsm.md
CONTROLLER_FSM -- requirements
Module: controller_fsm

Interface
REQ-001 SHALL have parameter D_ADDR_W, default 8, data-memory address width.
REQ-002 SHALL have parameter RF_ADDR_W, default 4, register-file address width.
REQ-003 SHALL have ports: Clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have ports: Reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: IR  in  16  current instruction from instruction register.
REQ-006 SHALL have ports: PC_clr  out  1  clear program counter; PC_up  out  1  increment PC; IR_ld  out  1  load IR.
REQ-007 SHALL have ports: D_Addr  out  D_ADDR_W  data-memory address; D_Wr  out  1  data-memory write enable.
REQ-008 SHALL have ports: RF_s  out  1  RF write-data select (1 = memory read data, 0 = ALU result); RF_W_en  out  1  RF write enable.
REQ-009 SHALL have ports: RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr  out  RF_ADDR_W each  RF write / read-A / read-B addresses.
REQ-010 SHALL have ports: ALU_s0  out  3  ALU op select (000 pass A, 001 add, 010 sub).

Function
REQ-011 SHALL implement states Init, Fetch, Decode, NoOp, LoadA, LoadB, Store, Add, Sub, Halt; state encoding 4 bits.
REQ-012 SHALL decode opcode IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; all other opcodes SHALL be treated as NOOP.
REQ-013 SHALL transition Init->Fetch->Decode unconditionally; Decode->{NoOp|LoadA|Store|Add|Sub|Halt} per opcode; LoadA->LoadB; NoOp, LoadB, Store, Add, Sub ->Fetch; Halt->Halt until Reset.
REQ-014 SHALL drive outputs as a Moore function of current state plus IR fields; every output not listed for a state SHALL be 0.
REQ-015 Init: PC_clr=1. Fetch: IR_ld=1, PC_up=1.
REQ-016 LOAD: D_Addr=IR[11:4], RF_W_Addr=IR[3:0]; LoadA drives D_Addr only (1-cycle memory read latency); LoadB additionally RF_s=1, RF_W_en=1.
REQ-017 STORE: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], ALU_s0=000, D_Wr=1 for exactly one cycle.
REQ-018 ADD/SUB: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_s=0, RF_W_en=1, ALU_s0=001 (Add) or 010 (Sub), one cycle.
REQ-019 Instruction latency SHALL be: NOOP/STORE/ADD/SUB 3 cycles Fetch-to-Fetch, LOAD 4 cycles.
REQ-020 D_Wr and RF_W_en SHALL never be asserted in the same cycle.

Reset
REQ-021 Reset high at a rising edge SHALL force state Init from any state, including mid-LOAD and Halt.
REQ-022 While in Init (after reset) outputs SHALL be PC_clr=1, all others 0; any D_Wr/RF_W_en of the interrupted instruction SHALL not occur after that edge.

Configuration
REQ-023 With CTRL_DEBUG_STATE_EN defined, SHALL add output State  out  4  current state encoding and output NextState  out  4  next-state encoding; without it those ports SHALL not exist and function is identical.

Structure
REQ-024 Package ctrl_pkg SHALL hold the state enum, opcode constants, and ALU select constants, shared with the datapath.
REQ-025 State register and next-state logic SHALL be separated; one sub-module, instr_field_decode (combinational IR field/opcode split), is natural.

Verification
REQ-026 Reset 2 cycles then release -> PC_clr=1 one cycle, then Fetch with IR_ld=1, PC_up=1.
REQ-027 IR=16'h2 1B5 (LOAD addr 0x1B->R5) -> LoadA D_Addr=0x1B, D_Wr=0; LoadB RF_s=1, RF_W_en=1, RF_W_Addr=5; back to Fetch after 4 cycles.
REQ-028 IR=16'h3 7A2 (ADD R7+R10->R2) -> one cycle ALU_s0=001, Ra=7, Rb=10, W=2, RF_W_en=1; IR=16'h4 7A2 -> same with ALU_s0=010.
REQ-029 IR=16'h1 3C4 (STORE R3->0xC4) -> one cycle D_Wr=1, D_Addr=0xC4, Ra=3, RF_W_en=0.
REQ-030 IR=16'h5000 -> Halt held 20 cycles, all outputs 0; IR=16'hF123 -> NoOp then Fetch.
REQ-031 Reset asserted during LoadA -> next cycle Init, no RF_W_en pulse; with CTRL_DEBUG_STATE_EN, State tracks every transition above.
